// File: rtl/dendrite_arbiter.sv
// dendrite_arbiter: incoming-priority arbiter with starvation guard and round-robin
// synapse ports, feeding a one-entry output register to the dendrite unit
module dendrite_arbiter #(
   parameter int STARVE_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] syn_dend_addr_0,
   input  logic [7:0] syn_dend_charge_0,
   input  logic       syn_dend_vld_0,
   output logic       syn_dend_rdy_0,
   input  logic [7:0] syn_dend_addr_1,
   input  logic [7:0] syn_dend_charge_1,
   input  logic       syn_dend_vld_1,
   output logic       syn_dend_rdy_1,
   input  logic [7:0] syn_dend_addr_2,
   input  logic [7:0] syn_dend_charge_2,
   input  logic       syn_dend_vld_2,
   output logic       syn_dend_rdy_2,
   input  logic [7:0] syn_dend_addr_3,
   input  logic [7:0] syn_dend_charge_3,
   input  logic       syn_dend_vld_3,
   output logic       syn_dend_rdy_3,
   input  logic [7:0] incoming_addr,
   input  logic [7:0] incoming_charge,
   input  logic       incoming_vld,
   output logic       incoming_rdy,
   output logic [7:0] dend_addr,
   output logic [8:0] dend_charge,
   output logic       dend_vld,
   input  logic       dend_rdy,
   output logic [2:0] dend_src
);
   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   logic [SW-1:0] starve;
   logic [1:0] rr_ptr, syn_sel, idx;
   logic [3:0] syn_vld;
   logic [7:0] syn_addr [4];
   logic [7:0] syn_charge [4];
   logic any_syn, sel_in, syn_hit, can_accept, grant_in, grant_syn, grant, starved;
   assign syn_vld = {syn_dend_vld_3, syn_dend_vld_2, syn_dend_vld_1, syn_dend_vld_0};
   assign syn_addr = '{syn_dend_addr_0, syn_dend_addr_1, syn_dend_addr_2, syn_dend_addr_3};
   assign syn_charge = '{syn_dend_charge_0, syn_dend_charge_1, syn_dend_charge_2, syn_dend_charge_3};
   assign any_syn = |syn_vld;
   assign starved = (starve == SW'(STARVE_LIMIT)) && any_syn;
   assign sel_in = incoming_vld && !starved;
   // reset gates acceptance so a vld seen during reset never transfers
   assign can_accept = enable && !reset && (!dend_vld || dend_rdy);
   always_comb begin
      syn_hit = 1'b0;
      syn_sel = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = rr_ptr + 2'(i);
         if (!syn_hit && syn_vld[idx]) begin
            syn_hit = 1'b1;
            syn_sel = idx;
         end
      end
   end
   assign grant_in = can_accept && sel_in;
   assign grant_syn = can_accept && !sel_in && syn_hit;
   assign grant = grant_in || grant_syn;
   assign incoming_rdy = grant_in;
   assign syn_dend_rdy_0 = grant_syn && (syn_sel == 2'd0);
   assign syn_dend_rdy_1 = grant_syn && (syn_sel == 2'd1);
   assign syn_dend_rdy_2 = grant_syn && (syn_sel == 2'd2);
   assign syn_dend_rdy_3 = grant_syn && (syn_sel == 2'd3);
   always_ff @(posedge clk) begin
      if (reset) begin
         dend_vld <= 1'b0;
         dend_addr <= '0;
         dend_charge <= '0;
         dend_src <= '0;
         rr_ptr <= '0;
         starve <= '0;
      end else begin
         if (grant) begin
            dend_vld <= 1'b1;
            dend_addr <= grant_in ? incoming_addr : syn_addr[syn_sel];
            dend_charge <= grant_in ? {1'b0, incoming_charge}
                                    : {syn_charge[syn_sel][7], syn_charge[syn_sel]};
            dend_src <= grant_in ? 3'd4 : {1'b0, syn_sel};
         end else if (dend_rdy) begin
            dend_vld <= 1'b0;
         end
         if (grant_syn) begin
            rr_ptr <= syn_sel + 2'd1;
            starve <= '0;
         end else if (grant_in) begin
            starve <= !any_syn ? '0 : (starve == SW'(STARVE_LIMIT)) ? starve : starve + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dendrite_arbiter.sv
// tb_dendrite_arbiter: directed self-checking bench for dendrite_arbiter
module tb_dendrite_arbiter;
   logic clk = 1'b0, reset, enable;
   logic [7:0] sa0, sa1, sa2, sa3, sc0, sc1, sc2, sc3;
   logic sv0, sv1, sv2, sv3, sr0, sr1, sr2, sr3;
   logic [7:0] in_addr, in_charge, dend_addr;
   logic in_vld, in_rdy, dend_vld, dend_rdy;
   logic [8:0] dend_charge;
   logic [2:0] dend_src;
   logic [4:0] rdy;
   int n_cmp = 0, n_err = 0;
   logic [8:0] exp_charge [4] = '{9'h1FF, 9'h001, 9'h180, 9'h07F};

   always #5 clk = ~clk;
   assign rdy = {in_rdy, sr3, sr2, sr1, sr0};

   dendrite_arbiter dut (
      .clk(clk), .reset(reset), .enable(enable),
      .syn_dend_addr_0(sa0), .syn_dend_charge_0(sc0), .syn_dend_vld_0(sv0), .syn_dend_rdy_0(sr0),
      .syn_dend_addr_1(sa1), .syn_dend_charge_1(sc1), .syn_dend_vld_1(sv1), .syn_dend_rdy_1(sr1),
      .syn_dend_addr_2(sa2), .syn_dend_charge_2(sc2), .syn_dend_vld_2(sv2), .syn_dend_rdy_2(sr2),
      .syn_dend_addr_3(sa3), .syn_dend_charge_3(sc3), .syn_dend_vld_3(sv3), .syn_dend_rdy_3(sr3),
      .incoming_addr(in_addr), .incoming_charge(in_charge), .incoming_vld(in_vld),
      .incoming_rdy(in_rdy), .dend_addr(dend_addr), .dend_charge(dend_charge),
      .dend_vld(dend_vld), .dend_rdy(dend_rdy), .dend_src(dend_src)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_syn(input logic [3:0] v);
      {sv3, sv2, sv1, sv0} = v;
   endtask

   initial begin
      sa0 = 8'h20; sa1 = 8'h21; sa2 = 8'h22; sa3 = 8'h23;
      sc0 = 8'hFF; sc1 = 8'h01; sc2 = 8'h80; sc3 = 8'h7F;
      in_addr = 8'h12; in_charge = 8'h80;
      reset = 1'b1; enable = 1'b1; dend_rdy = 1'b1;
      set_syn(4'hF); in_vld = 1'b1;
      tick;
      #1 chk("rdy_in_reset", 16'(rdy), 16'h0);
      tick;
      chk("reset_vld", 16'(dend_vld), 16'h0);
      chk("reset_addr", 16'(dend_addr), 16'h0);
      chk("reset_charge", 16'(dend_charge), 16'h0);
      chk("reset_src", 16'(dend_src), 16'h0);
      reset = 1'b0; set_syn(4'h0); in_vld = 1'b0;
      #1 chk("idle_rdy", 16'(rdy), 16'h0);
      // single incoming fire, zero-extended charge
      in_vld = 1'b1;
      #1 chk("in_rdy", 16'(rdy), 16'h10);
      tick;
      in_vld = 1'b0;
      #1 chk("in_rdy_once", 16'(rdy), 16'h0);
      chk("in_vld_out", 16'(dend_vld), 16'h1);
      chk("in_addr_out", 16'(dend_addr), 16'h12);
      chk("in_charge_out", 16'(dend_charge), 16'h080);
      chk("in_src_out", 16'(dend_src), 16'h4);
      tick;
      chk("drained", 16'(dend_vld), 16'h0);
      // round robin across all synapse ports, sign-extended charges
      set_syn(4'hF);
      for (int i = 0; i < 6; i++) begin
         #1 chk("rr_rdy", 16'(rdy), 16'(1 << (i % 4)));
         tick;
         chk("rr_src", 16'(dend_src), 16'(i % 4));
         chk("rr_addr", 16'(dend_addr), 16'(8'h20 + i % 4));
         chk("rr_charge", 16'(dend_charge), 16'(exp_charge[i % 4]));
      end
      // starvation guard: 15 incoming grants then one port-2 grant
      set_syn(4'b0100); in_vld = 1'b1;
      for (int i = 0; i < 32; i++) begin
         #1 chk("starve_rdy", 16'(rdy), (i % 16 == 15) ? 16'h04 : 16'h10);
         tick;
      end
      set_syn(4'h0); in_vld = 1'b0;
      chk("starve_last_src", 16'(dend_src), 16'h2);
      tick;
      chk("starve_drain", 16'(dend_vld), 16'h0);
      // backpressure: one grant, then frozen output
      dend_rdy = 1'b0; set_syn(4'hF);
      #1 chk("bp_first_rdy", 16'(rdy), 16'h08);
      tick;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_rdy_low", 16'(rdy), 16'h0);
         chk("bp_vld", 16'(dend_vld), 16'h1);
         chk("bp_src", 16'(dend_src), 16'h3);
         chk("bp_addr", 16'(dend_addr), 16'h23);
         tick;
      end
      dend_rdy = 1'b1;
      #1 chk("bp_resume_rdy", 16'(rdy), 16'h01);
      tick;
      chk("bp_resume_src0", 16'(dend_src), 16'h0);
      #1 chk("bp_b2b_rdy", 16'(rdy), 16'h02);
      tick;
      chk("bp_resume_src1", 16'(dend_src), 16'h1);
      chk("bp_resume_vld", 16'(dend_vld), 16'h1);
      // enable low freezes arbitration while the buffered fire drains
      enable = 1'b0; dend_rdy = 1'b0; in_vld = 1'b1;
      #1 chk("en_rdy_low", 16'(rdy), 16'h0);
      tick;
      chk("en_hold_vld", 16'(dend_vld), 16'h1);
      chk("en_hold_src", 16'(dend_src), 16'h1);
      dend_rdy = 1'b1;
      #1 chk("en_rdy_low2", 16'(rdy), 16'h0);
      tick;
      chk("en_drained", 16'(dend_vld), 16'h0);
      enable = 1'b1; in_vld = 1'b0;
      #1 chk("en_resume_rdy", 16'(rdy), 16'h04);
      tick;
      chk("en_resume_src", 16'(dend_src), 16'h2);
      // reset mid-stream discards the buffered fire and rr_ptr
      reset = 1'b1;
      #1 chk("rst_mid_rdy", 16'(rdy), 16'h0);
      tick;
      chk("rst_mid_vld", 16'(dend_vld), 16'h0);
      chk("rst_mid_src", 16'(dend_src), 16'h0);
      reset = 1'b0;
      #1 chk("rst_after_rdy", 16'(rdy), 16'h01);
      tick;
      chk("rst_after_src", 16'(dend_src), 16'h0);
      chk("rst_after_charge", 16'(dend_charge), 16'h1FF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
